// File: rtl/fir4_sum_decoder.sv
// fir4_sum_decoder
//   Recovers the w-bit samples x[n] from the (w+2)-bit stream of a 4-tap moving
//   sum y[n] = x[n]+x[n-1]+x[n-2]+x[n-3], using x[n] = y[n] - y[n-1] + x[n-4].
//   It sits at the receive end of a link that carries FIR output and is used for
//   loopback and self-check.
//   A sum stream that cannot come from w-bit unsigned samples halts the decoder
//   with a sticky err. Only reset or clr brings it back to RUN.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   RUN   | normal decode; one input accepted per output slot
//   ERR   | halted after an inconsistent sum; in_ready=0, err=1, pending word
//         | still drains; only reset or clr leave this state
//
// Ports
//   clk        clock, all state updates on posedge
//   reset      synchronous active-high reset, clears all state
//   clr        synchronous resync, same effect as reset
//   in_data    FIR sum sample y[n] (w+2 bits, unsigned)
//   in_valid   in_data valid
//   in_ready   decoder accepts in_data this cycle
//   out_data   recovered sample x[n] (w bits, unsigned), registered
//   out_valid  out_data valid, registered
//   out_ready  downstream accepts out_data
//   err        sticky stream-inconsistency flag
//   count      samples delivered since reset/clr, saturating

module fir4_sum_decoder #(
    parameter int w     = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [w+1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [w-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err,
    output logic [CNT_W-1:0] count
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ERR = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q,     state_d;
    logic [w+1:0]       y_prev_q,    y_prev_d;
    logic [w-1:0]       x_hist_q [4];
    logic [w-1:0]       x_hist_d [4];
    logic [w-1:0]       out_data_q,  out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q,       err_d;
    logic [CNT_W-1:0]   count_q,     count_d;

    logic               in_xfer;
    logic               out_xfer;
    logic signed [w+3:0] diff;
    logic               diff_ok;

    // Two extra bits over the sum width hold y - y_prev + x[n-4] exactly:
    // the result lies in (-2^(w+2), 2^(w+2)+2^w), so no wrap can occur.
    always_comb begin
        diff = $signed({2'b00, in_data})
             - $signed({2'b00, y_prev_q})
             + $signed({4'b0000, x_hist_q[3]});
        diff_ok = (diff[w+3:w] == 4'b0000);
    end

    always_comb begin
        in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
        in_xfer  = in_valid && in_ready;
        out_xfer = out_valid_q && out_ready;
    end

    always_comb begin
        state_d     = state_q;
        y_prev_d    = y_prev_q;
        x_hist_d    = x_hist_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        count_d     = count_q;

        if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        if (in_xfer) begin
            if (diff_ok) begin
                out_data_d  = diff[w-1:0];
                out_valid_d = 1'b1;
                x_hist_d[3] = x_hist_q[2];
                x_hist_d[2] = x_hist_q[1];
                x_hist_d[1] = x_hist_q[0];
                x_hist_d[0] = diff[w-1:0];
                y_prev_d    = in_data;
                if (count_q != CNT_MAX) begin
                    count_d = count_q + CNT_ONE;
                end
            end else begin
                // Offending sample is dropped; history stays as it was so the
                // decoder state still reflects the last consistent sample.
                state_d = ST_ERR;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            state_q     <= ST_RUN;
            y_prev_q    <= '0;
            x_hist_q    <= '{default: '0};
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            y_prev_q    <= y_prev_d;
            x_hist_q    <= x_hist_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            count_q     <= count_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign count     = count_q;

endmodule

// File: tb/tb_fir4_sum_decoder.sv
module tb_fir4_sum_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic [17:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        err;
    logic [15:0] count;

    fir4_sum_decoder #(.w(16), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: list of recovered samples plus previous sum.
    int m_x[$];
    int m_yprev;
    bit m_err;
    bit m_ov;
    int m_od;
    int m_cnt;

    // Stimulus generator: a 4-tap moving sum over random samples.
    int g[3];
    bit have_offer;
    int offer_y;
    int offer_x;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_x = {0, 0, 0, 0};
        m_yprev = 0;
        m_err = 0;
        m_ov = 0;
        m_od = 0;
        m_cnt = 0;
    endtask

    task automatic step(input bit v, input int y, input bit ordy, input bit c,
                        input bit r, output bit acc);
        bit exp_rdy;
        int d;
        @(negedge clk);
        in_valid  = v;
        in_data   = y[17:0];
        out_ready = ordy;
        clr       = c;
        reset     = r;
        #1;
        exp_rdy = !m_err && (!m_ov || ordy);
        check("in_ready", in_ready, exp_rdy);
        acc = 0;
        if (r || c) begin
            model_reset();
        end else begin
            if (m_ov && ordy) m_ov = 0;
            if (v && exp_rdy) begin
                acc = 1;
                d = y - m_yprev + m_x[m_x.size()-4];
                if (d >= 0 && d <= 65535) begin
                    m_od = d;
                    m_ov = 1;
                    m_x.push_back(d);
                    if (m_x.size() > 4) void'(m_x.pop_front());
                    m_yprev = y;
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    m_err = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_ov);
        if (m_ov) check("out_data", out_data, m_od);
        check("err", err, m_err);
        check("count", count, m_cnt);
    endtask

    task automatic do_reset();
        bit acc;
        step(0, 0, 1, 0, 1, acc);
        check("rst_out_data", out_data, 0);
    endtask

    task automatic run_t1();
        bit acc;
        int ys[6] = '{1, 3, 6, 10, 14, 18};
        for (int i = 0; i < 6; i++) begin
            step(1, ys[i], 1, 0, 0, acc);
            check("t1_x", out_data, i + 1);
        end
        check("t1_count", count, 6);
        check("t1_err", err, 0);
    endtask

    initial begin
        bit acc;
        int ys2[5] = '{65535, 131070, 196605, 262140, 262140};
        reset = 1; clr = 0; in_valid = 0; in_data = '0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_err", err, 0);
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);

        // Basic decode
        do_reset();
        run_t1();

        // Max values
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, ys2[i], 1, 0, 0, acc);
            check("t2_x", out_data, 65535);
        end
        check("t2_err", err, 0);

        // Inconsistent stream
        do_reset();
        step(1, 5, 1, 0, 0, acc);
        check("t3_x", out_data, 5);
        step(1, 2, 1, 0, 0, acc);
        check("t3_err", err, 1);
        check("t3_count", count, 1);
        check("t3_in_ready", in_ready, 0);
        step(1, 2, 1, 0, 0, acc);
        check("t3_no_out", out_valid, 0);

        // Clear out of ERR
        step(0, 0, 1, 1, 0, acc);
        check("t5_err", err, 0);
        step(1, 7, 1, 0, 0, acc);
        check("t5_x0", out_data, 7);
        step(1, 7, 1, 0, 0, acc);
        check("t5_x1", out_data, 0);
        check("t5_count", count, 2);

        // Backpressure
        do_reset();
        step(1, 1, 1, 0, 0, acc);
        for (int i = 0; i < 3; i++) begin
            step(1, 3, 0, 0, 0, acc);
            check("t4_hold", out_data, 1);
            check("t4_rdy", in_ready, 0);
        end
        step(1, 3, 1, 0, 0, acc);
        check("t4_x2", out_data, 2);
        step(1, 6, 1, 0, 0, acc);
        check("t4_x3", out_data, 3);
        step(1, 10, 1, 0, 0, acc);
        check("t4_x4", out_data, 4);

        // Reset while a word is pending under backpressure
        do_reset();
        step(1, 1, 1, 0, 0, acc);
        step(1, 3, 0, 0, 0, acc);
        step(1, 3, 0, 0, 1, acc);
        check("t6_ov", out_valid, 0);
        check("t6_count", count, 0);
        run_t1();

        // Randomized traffic
        do_reset();
        g = '{0, 0, 0};
        have_offer = 0;
        for (int i = 0; i < 4000; i++) begin
            bit r, c, v, ordy;
            r = ($urandom_range(0, 499) == 0);
            c = !r && ((m_err && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 9) < 7);
            if (!have_offer) begin
                case ($urandom_range(0, 3))
                    0: offer_x = 65535;
                    1: offer_x = 0;
                    default: offer_x = $urandom_range(0, 65535);
                endcase
                offer_y = offer_x + g[0] + g[1] + g[2];
                if ($urandom_range(0, 63) == 0) offer_y = $urandom_range(0, 262143);
                have_offer = 1;
            end
            step(v, offer_y, ordy, c, r, acc);
            if (r || c) begin
                g = '{0, 0, 0};
                have_offer = 0;
            end else if (acc) begin
                g[2] = g[1];
                g[1] = g[0];
                g[0] = offer_x;
                have_offer = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
